// File: rtl/rca_lsq_types.sv
// Shared types and constants for the RCA load/store request port.
package rca_lsq_types;

  localparam int unsigned LSQ_XLEN = 32;

  // RISC-V load/store funct3 encodings.
  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef struct packed {
    logic [LSQ_XLEN-1:0] addr;
    logic [LSQ_XLEN-1:0] data;
    logic [2:0]          fn3;
    logic                is_load;
  } lsq_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_LOAD
  } lsq_state_t;

endpackage

// File: rtl/rca_lsq_fifo.sv
// In-order circular queue of load/store entries. Caller must not push
// when full or pop when empty.
module rca_lsq_fifo
  import rca_lsq_types::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  lsq_entry_t                 wr_entry,
  output lsq_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  lsq_entry_t        entries [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      entries[wr_ptr] <= wr_entry;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = entries[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/rca_lsq_port.sv
// Responder side of the OU load/store interface: queues requests, issues
// them in order to the data-memory port, and returns extended load data.
module rca_lsq_port
  import rca_lsq_types::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] data,
  input  logic [2:0]      fn3,
  input  logic            load,
  input  logic            store,
  input  logic            new_request,
  output logic            lsq_full,
  output logic [XLEN-1:0] load_data,
  output logic            load_complete,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  output logic            mem_we,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_rvalid
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  lsq_state_t        state;
  lsq_state_t        state_next;
  lsq_entry_t        in_entry;
  lsq_entry_t        head;
  logic [CW-1:0]     count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              rvalid_take;
  logic [2:0]        ld_fn3;
  logic [1:0]        ld_off;

  // Store data replication and byte enables; returns {wdata, be}.
  function automatic logic [35:0] steer(input logic [31:0] d,
                                        input logic [2:0]  f,
                                        input logic [1:0]  off);
    case (f)
      LS_B:    steer = {{4{d[7:0]}}, 4'b0001 << off};
      LS_H:    steer = {{2{d[15:0]}}, (off[1] ? 4'b1100 : 4'b0011)};
      LS_W:    steer = {d, 4'b1111};
      default: steer = {d, 4'b1111};
    endcase
  endfunction

  // Select the addressed byte/half of the read word and extend it.
  function automatic logic [31:0] extract(input logic [31:0] rd,
                                          input logic [2:0]  f,
                                          input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{off, 3'b000} +: 8];
    h = off[1] ? rd[31:16] : rd[15:0];
    case (f)
      LS_B:    extract = {{24{b[7]}}, b};
      LS_BU:   extract = {24'b0, b};
      LS_H:    extract = {{16{h[15]}}, h};
      LS_HU:   extract = {16'b0, h};
      default: extract = rd;
    endcase
  endfunction

  // A request with both load and store set is a load; with neither it is dropped.
  assign push        = new_request && !fifo_full && (load || store);
  assign lsq_full    = fifo_full;
  assign rvalid_take = (state == WAIT_LOAD) && mem_rvalid;

  // Pack the incoming request into a queue entry.
  always_comb begin
    in_entry.addr    = addr;
    in_entry.data    = data;
    in_entry.fn3     = fn3;
    in_entry.is_load = load;
  end

  rca_lsq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .wr_entry (in_entry),
    .head     (head),
    .count    (count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next state and memory-port drive. A same-cycle push counts as occupancy
  // so a fresh request reaches mem_req on the very next cycle.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    mem_req    = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_be     = '0;
    mem_we     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty || push) state_next = ISSUE;
      end
      ISSUE: begin
        mem_req  = 1'b1;
        mem_addr = {head.addr[LSQ_XLEN-1:2], 2'b00};
        mem_we   = !head.is_load;
        if (head.is_load) mem_be = 4'b1111;
        else {mem_wdata, mem_be} = steer(head.data, head.fn3, head.addr[1:0]);
        if (mem_ack) begin
          pop = 1'b1;
          if (head.is_load)                 state_next = WAIT_LOAD;
          else if ((count > CW'(1)) || push) state_next = ISSUE;
          else                              state_next = IDLE;
        end
      end
      WAIT_LOAD: begin
        if (mem_rvalid) state_next = (!fifo_empty || push) ? ISSUE : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture access size and byte offset of the load being issued.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ld_fn3 <= '0;
      ld_off <= '0;
    end else if (pop && head.is_load) begin
      ld_fn3 <= head.fn3;
      ld_off <= head.addr[1:0];
    end
  end

  // Register load result and completion strobe; data holds between loads.
  always_ff @(posedge clk) begin
    if (!rst) begin
      load_complete <= 1'b0;
      load_data     <= '0;
    end else begin
      load_complete <= rvalid_take;
      if (rvalid_take) load_data <= extract(mem_rdata, ld_fn3, ld_off);
    end
  end

endmodule

// File: tb/tb_rca_lsq_port.sv
// Self-checking bench for rca_lsq_port with a scoreboard of expected memory
// transactions and load results.
module tb_rca_lsq_port;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] data;
  logic [2:0]  fn3;
  logic        load;
  logic        store;
  logic        new_request;
  logic        lsq_full;
  logic [31:0] load_data;
  logic        load_complete;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_we;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
  } mtx_t;

  mtx_t        exp_mem [$];
  logic [31:0] exp_ld  [$];
  logic [31:0] rdata_q [$];

  int tests_run = 0;
  int failed    = 0;
  int hs_count  = 0;
  int req_seen  = 0;
  int rv_delay  = 0;
  bit rv_pending = 0;
  int rv_cnt    = 0;
  bit ld_out    = 0;

  always #5 clk = ~clk;

  rca_lsq_port #(
    .DEPTH(4),
    .XLEN (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .addr          (addr),
    .data          (data),
    .fn3           (fn3),
    .load          (load),
    .store         (store),
    .new_request   (new_request),
    .lsq_full      (lsq_full),
    .load_data     (load_data),
    .load_complete (load_complete),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_be        (mem_be),
    .mem_we        (mem_we),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .mem_rvalid    (mem_rvalid)
  );

  function automatic mtx_t mk(input logic [31:0] a, input logic [31:0] w,
                              input logic [3:0] b, input logic we);
    mtx_t t;
    t.addr = a; t.wdata = w; t.be = b; t.we = we;
    return t;
  endfunction

  // Monitor and memory responder, all on the falling edge.
  initial begin
    mtx_t        e;
    logic [31:0] ev;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (rv_pending) begin
        if (rv_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = (rdata_q.size() > 0) ? rdata_q.pop_front() : 32'h0;
          rv_pending = 0;
        end else begin
          rv_cnt--;
        end
      end
      if (mem_req) req_seen++;
      if (!rst) begin
        ld_out = 0;
      end else begin
        if (load_complete) begin
          tests_run++;
          if (exp_ld.size() == 0) begin
            failed++;
            $display("FAIL unexpected_load_complete: got load_data=%h, required no strobe", load_data);
          end else begin
            ev = exp_ld.pop_front();
            if (load_data !== ev) begin
              failed++;
              $display("FAIL load_data: got %h, required %h", load_data, ev);
            end
          end
          ld_out = 0;
        end
        if (mem_req && mem_ack) begin
          hs_count++;
          tests_run++;
          if (ld_out) begin
            failed++;
            $display("FAIL ordering: got mem_req at %h while a load is outstanding, required none", mem_addr);
          end else if (exp_mem.size() == 0) begin
            failed++;
            $display("FAIL unexpected_mem_req: got addr=%h we=%b, required no request", mem_addr, mem_we);
          end else begin
            e = exp_mem.pop_front();
            if (mem_addr !== e.addr || mem_be !== e.be || mem_we !== e.we ||
                (e.we && mem_wdata !== e.wdata)) begin
              failed++;
              $display("FAIL mem_txn: got addr=%h wdata=%h be=%b we=%b, required addr=%h wdata=%h be=%b we=%b",
                       mem_addr, mem_wdata, mem_be, mem_we, e.addr, e.wdata, e.be, e.we);
            end
          end
          if (!mem_we) begin
            ld_out     = 1;
            rv_pending = 1;
            rv_cnt     = rv_delay;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog");
  end

  // Present one request for one cycle; call and return at posedge+1.
  task automatic send(input logic ld, input logic st, input logic [2:0] f,
                      input logic [31:0] a, input logic [31:0] d);
    load = ld; store = st; fn3 = f; addr = a; data = d; new_request = 1'b1;
    @(posedge clk); #1;
    new_request = 1'b0; load = 1'b0; store = 1'b0;
  endtask

  task automatic wait_drain(input int bound, input string name);
    bit done = 0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clk);
      if (exp_mem.size() == 0 && exp_ld.size() == 0) done = 1;
    end
    tests_run++;
    if (!done) begin
      failed++;
      $display("FAIL %s_drain: got %0d mem / %0d load pending, required 0", name, exp_mem.size(), exp_ld.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({lsq_full, load_complete, mem_req, mem_we} !== 4'b0) begin
      failed++;
      $display("FAIL reset_flags: got full=%b lc=%b req=%b we=%b, required 0", lsq_full, load_complete, mem_req, mem_we);
    end
    tests_run++;
    if (load_data !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_be !== 4'h0) begin
      failed++;
      $display("FAIL reset_data: got ld=%h addr=%h wdata=%h be=%b, required 0", load_data, mem_addr, mem_wdata, mem_be);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_store_lanes();
    logic [2:0]  t_f  [4] = '{3'b000, 3'b001, 3'b001, 3'b010};
    logic [31:0] t_a  [4] = '{32'h1000, 32'h1002, 32'h1001, 32'h1004};
    logic [31:0] t_d  [4] = '{32'h0000005A, 32'h0000BEEF, 32'hFFFF1234, 32'hDEADBEEF};
    logic [31:0] t_w  [4] = '{32'h5A5A5A5A, 32'hBEEFBEEF, 32'h12341234, 32'hDEADBEEF};
    logic [31:0] t_ma [4] = '{32'h1000, 32'h1000, 32'h1000, 32'h1004};
    logic [3:0]  t_be [4] = '{4'b0001, 4'b1100, 4'b0011, 4'b1111};
    mem_ack = 1'b1;
    exp_mem.push_back(mk(32'h1000, 32'hABABABAB, 4'b1000, 1'b1));
    send(1'b0, 1'b1, 3'b000, 32'h1003, 32'h123456AB);
    @(negedge clk);
    tests_run++;
    if (mem_req !== 1'b1) begin
      failed++;
      $display("FAIL issue_latency: got mem_req=%b one cycle after enqueue, required 1", mem_req);
    end
    @(posedge clk); #1;
    wait_drain(20, "sb");
    for (int i = 0; i < 4; i++) begin
      exp_mem.push_back(mk(t_ma[i], t_w[i], t_be[i], 1'b1));
      send(1'b0, 1'b1, t_f[i], t_a[i], t_d[i]);
    end
    wait_drain(30, "store_lanes");
  endtask

  task automatic test_loads();
    logic [2:0]  t_f  [7] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b000, 3'b010, 3'b101};
    logic        t_st [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] t_a  [7] = '{32'h2001, 32'h2001, 32'h2002, 32'h2002, 32'h2003, 32'h2004, 32'h2000};
    logic [31:0] t_rd [7] = '{32'h0000F600, 32'h0000F600, 32'h80011234, 32'h80011234,
                              32'h7F000000, 32'hCAFEF00D, 32'h80019ABC};
    logic [31:0] t_ex [7] = '{32'hFFFFFFF6, 32'h000000F6, 32'h00008001, 32'hFFFF8001,
                              32'h0000007F, 32'hCAFEF00D, 32'h00009ABC};
    mem_ack  = 1'b1;
    rv_delay = 0;
    for (int i = 0; i < 7; i++) begin
      exp_mem.push_back(mk({t_a[i][31:2], 2'b00}, 32'h0, 4'b1111, 1'b0));
      exp_ld.push_back(t_ex[i]);
      rdata_q.push_back(t_rd[i]);
      send(1'b1, t_st[i], t_f[i], t_a[i], 32'hFFFFFFFF);
    end
    wait_drain(80, "loads");
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (load_data !== 32'h00009ABC) begin
      failed++;
      $display("FAIL load_data_hold: got %h, required %h", load_data, 32'h00009ABC);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int h0;
    mem_ack = 1'b1;
    h0 = hs_count;
    for (int i = 0; i < 3; i++) begin
      exp_mem.push_back(mk(32'h7000 + 32'(4 * i), 32'h11111111 * (i + 1), 4'b1111, 1'b1));
      send(1'b0, 1'b1, 3'b010, 32'h7000 + 32'(4 * i), 32'h11111111 * (i + 1));
    end
    @(posedge clk); #1;
    tests_run++;
    if (hs_count - h0 !== 3) begin
      failed++;
      $display("FAIL back_to_back: got %0d stores in 3 cycles, required 3", hs_count - h0);
    end
    wait_drain(20, "back_to_back");
  endtask

  task automatic test_full();
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_mem.push_back(mk(32'h6000 + 32'(4 * i), 32'hA0A0A0A0 + 32'(i), 4'b1111, 1'b1));
      send(1'b0, 1'b1, 3'b010, 32'h6000 + 32'(4 * i), 32'hA0A0A0A0 + 32'(i));
    end
    @(negedge clk);
    tests_run++;
    if (lsq_full !== 1'b1) begin
      failed++;
      $display("FAIL full_set: got lsq_full=%b, required 1", lsq_full);
    end
    @(posedge clk); #1;
    store = 1'b1; fn3 = 3'b010; addr = 32'h6010; data = 32'hBAD0BAD0; new_request = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (lsq_full !== 1'b1) begin
      failed++;
      $display("FAIL full_hold: got lsq_full=%b while stalled, required 1", lsq_full);
    end
    @(posedge clk); #1;
    new_request = 1'b0; store = 1'b0;
    mem_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (lsq_full !== 1'b0) begin
      failed++;
      $display("FAIL full_clear: got lsq_full=%b after first pop, required 0", lsq_full);
    end
    @(posedge clk); #1;
    wait_drain(20, "full");
  endtask

  task automatic test_load_then_store();
    mem_ack  = 1'b1;
    rv_delay = 5;
    exp_mem.push_back(mk(32'h8000, 32'h0, 4'b1111, 1'b0));
    exp_ld.push_back(32'h0BADF00D);
    rdata_q.push_back(32'h0BADF00D);
    exp_mem.push_back(mk(32'h8004, 32'h55AA55AA, 4'b1111, 1'b1));
    send(1'b1, 1'b0, 3'b010, 32'h8000, 32'h0);
    send(1'b0, 1'b1, 3'b010, 32'h8004, 32'h55AA55AA);
    wait_drain(40, "load_then_store");
    rv_delay = 0;
  endtask

  task automatic test_no_op();
    int r0;
    mem_ack = 1'b1;
    r0 = req_seen;
    send(1'b0, 1'b0, 3'b010, 32'h9000, 32'hFFFFFFFF);
    repeat (4) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (req_seen != r0 || lsq_full !== 1'b0) begin
      failed++;
      $display("FAIL no_op: got %0d requests full=%b, required 0 requests full=0", req_seen - r0, lsq_full);
    end
    @(posedge clk); #1;
    exp_mem.push_back(mk(32'h9000, 32'h77777777, 4'b0100, 1'b1));
    send(1'b0, 1'b1, 3'b000, 32'h9002, 32'h00000077);
    wait_drain(20, "no_op");
  endtask

  task automatic test_reset_mid_load();
    int r0;
    mem_ack  = 1'b1;
    rv_delay = 10;
    exp_mem.push_back(mk(32'h4000, 32'h0, 4'b1111, 1'b0));
    rdata_q.push_back(32'h12345678);
    send(1'b1, 1'b0, 3'b000, 32'h4000, 32'h0);
    send(1'b0, 1'b1, 3'b010, 32'h5000, 32'h11112222);
    send(1'b0, 1'b1, 3'b010, 32'h5004, 32'h33334444);
    @(negedge clk);
    tests_run++;
    if (mem_req !== 1'b0) begin
      failed++;
      $display("FAIL wait_load_req: got mem_req=%b while waiting for load data, required 0", mem_req);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({lsq_full, mem_req, load_complete} !== 3'b000) begin
      failed++;
      $display("FAIL mid_reset: got full=%b req=%b lc=%b, required 000", lsq_full, mem_req, load_complete);
    end
    r0 = req_seen;
    repeat (14) @(negedge clk);
    tests_run++;
    if (req_seen != r0 || rv_pending) begin
      failed++;
      $display("FAIL mid_reset_flush: got %0d requests pending_rvalid=%b, required 0 and 0", req_seen - r0, rv_pending);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0; addr = '0; data = '0; fn3 = '0;
    load = 1'b0; store = 1'b0; new_request = 1'b0; mem_ack = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_store_lanes();
    test_loads();
    test_back_to_back();
    test_full();
    test_load_then_store();
    test_no_op();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/rca_lsq_port.md
Name: rca_lsq_port

Overview:
- Responder end of the RCA operation-unit load/store request interface.
- Accepts addr/data/fn3/load/store requests from one OU and buffers them in a small in-order queue.
- Issues them one at a time to the data-memory port with byte-lane steering.
- Returns aligned, sign/zero-extended load data to the OU with a one-cycle load_complete pulse.

Parameters:
- DEPTH, 4, queue entries; power of two, minimum 2.
- XLEN, 32 (from taiga_config), data/address width; lane logic is fixed for 32.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- addr  in  XLEN  OU request byte address
- data  in  XLEN  OU store data, right-aligned
- fn3  in  3  RISC-V funct3 of the access
- load  in  1  request is a load
- store  in  1  request is a store
- new_request  in  1  OU request valid
- lsq_full  out  1  queue cannot accept this cycle
- load_data  out  XLEN  aligned, extended load result
- load_complete  out  1  one-cycle load result strobe
- mem_req  out  1  memory request valid
- mem_addr  out  XLEN  word address; bits [1:0] forced to 0
- mem_wdata  out  XLEN  lane-replicated store data
- mem_be  out  4  byte enables (stores); all ones for loads
- mem_we  out  1  1 = store, 0 = load
- mem_ack  in  1  memory accepted the current mem_req
- mem_rdata  in  XLEN  load read data
- mem_rvalid  in  1  mem_rdata valid

Behaviour:
- Reset (rst==0 at a clk edge):
  - Outputs: lsq_full=0, load_complete=0, load_data=0, mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0, mem_we=0.
  - Queue emptied, FSM to IDLE.
  - A pending load is discarded; a mem_rvalid arriving later is ignored.
- Enqueue:
  - Occurs when new_request && !lsq_full.
  - lsq_full = (count==DEPTH), combinational from the registered count only. A pop in the same cycle does not clear it (conservative).
  - load && store both high: treated as a load.
  - Neither high: request consumed, nothing enqueued.
- Queue:
  - Circular, in order; pointers wrap modulo DEPTH.
  - Simultaneous push and pop leaves count unchanged.
- FSM states:
  - IDLE: queue non-empty -> ISSUE (next cycle). A request enqueued at edge N drives mem_req from cycle N+1.
  - ISSUE:
    - mem_req=1, fields from the head entry, held stable until mem_ack.
    - On mem_ack: store pops and goes to IDLE, or to ISSUE if more entries remain (back-to-back stores, one per cycle at most).
    - On mem_ack: load pops, latches fn3 and addr[1:0], goes to WAIT_LOAD.
  - WAIT_LOAD:
    - mem_req=0; only one load outstanding.
    - mem_rvalid -> register the result. load_complete=1 and load_data valid on the following cycle (M+1).
    - Next state IDLE/ISSUE per queue occupancy.
    - mem_rvalid outside WAIT_LOAD is ignored.
- Store lane steering:
  - fn3 000 (SB): wdata = data[7:0] replicated x4, be = 0001 << addr[1:0].
  - fn3 001 (SH): wdata = data[15:0] x2, be = addr[1] ? 1100 : 0011; addr[0] ignored.
  - Any other fn3: word, be = 1111.
- Load extraction:
  - fn3 000 (LB): byte addr[1:0], sign-extended.
  - fn3 100 (LBU): byte addr[1:0], zero-extended.
  - fn3 001 (LH): half addr[1], sign-extended.
  - fn3 101 (LHU): half addr[1], zero-extended.
  - Any other fn3: full word.
- Ordering: strict program order; a store never overtakes an earlier load.
- load_data holds its value until the next load_complete.

Decomposition:
- Package rca_lsq_types:
  - lsq_entry_t {addr, data, fn3, is_load}.
  - FSM enum {IDLE, ISSUE, WAIT_LOAD}.
  - Reuse the LS_B/LS_H/LS_W fn3 constants from riscv_types.
- Sub-module rca_lsq_fifo: parameterised DEPTH queue of lsq_entry_t with push/pop/count/full/empty.
- Lane steering and extraction stay as functions in rca_lsq_port.

Test Plan:
- SB addr=0x1003 data=0xAB, mem_ack same cycle -> mem_req one cycle later, mem_addr=0x1000, mem_be=1000, mem_wdata=0xABABABAB, mem_we=1; queue empty afterwards.
- LB addr=0x2001, mem_rdata=0x0000F600 on rvalid -> load_complete one cycle later, load_data=0xFFFFFFF6. Same with LBU -> 0x000000F6. LHU addr=0x2002, rdata=0x8001xxxx -> 0x00008001.
- Hold mem_ack=0, push DEPTH(4) stores -> lsq_full=1. Fifth request with new_request=1 is not accepted. Release ack -> four stores issue in order, lsq_full drops after the first pop.
- Load followed by store, delay mem_rvalid 5 cycles -> no mem_req during WAIT_LOAD. Store issues only after load_complete.
- Assert rst=0 during WAIT_LOAD with 2 entries queued, then send mem_rvalid -> no load_complete, lsq_full=0, mem_req=0, queue empty.
- new_request with load=store=0 -> nothing issued, count unchanged.
